// File: rtl/reg_scoreboard.sv
// Register-result scoreboard for the ID stage: tracks in-flight GPR writes,
// counts down forwarding latency and raises ID stall on RAW/WAW hazards.
module reg_scoreboard #(
  parameter int REG_NUM = 32,
  parameter int CNT_W   = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  input  logic               issue_we_i,
  input  logic [4:0]         issue_waddr_i,
  input  logic [CNT_W-1:0]   issue_lat_i,
  input  logic               issue_re1_i,
  input  logic [4:0]         issue_raddr1_i,
  input  logic               issue_re2_i,
  input  logic [4:0]         issue_raddr2_i,
  input  logic               wb_valid_i,
  input  logic [4:0]         wb_waddr_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic [REG_NUM-1:0] busy_o
);

  logic [1:0]       inflight_q [REG_NUM];
  logic [CNT_W-1:0] cnt_q      [REG_NUM];

  logic haz1;
  logic haz2;
  logic waw;
  logic accept;

  logic [REG_NUM-1:0] acc_vec;
  logic [REG_NUM-1:0] wb_vec;

  always_comb begin
    haz1 = issue_re1_i
        && (issue_raddr1_i != 5'd0)
        && (inflight_q[issue_raddr1_i] != 2'd0)
        && (cnt_q[issue_raddr1_i] != '0);
    haz2 = issue_re2_i
        && (issue_raddr2_i != 5'd0)
        && (inflight_q[issue_raddr2_i] != 2'd0)
        && (cnt_q[issue_raddr2_i] != '0);
    // Older unfinished producer, or 2-bit in-flight count already full
    waw  = issue_we_i
        && (issue_waddr_i != 5'd0)
        && ((cnt_q[issue_waddr_i] != '0)
         || (inflight_q[issue_waddr_i] == 2'd3));
    stall_o = issue_valid_i && (haz1 || haz2 || waw) && !rst_i;
    accept  = issue_valid_i && issue_we_i
           && (issue_waddr_i != 5'd0)
           && !stall_o && !flush_i;
  end

  always_comb begin
    acc_vec = '0;
    wb_vec  = '0;
    busy_o  = '0;
    for (int r = 1; r < REG_NUM; r++) begin
      acc_vec[r] = accept && (issue_waddr_i == 5'(r));
      wb_vec[r]  = wb_valid_i
                && (wb_waddr_i == 5'(r))
                && (inflight_q[r] != 2'd0);
      busy_o[r]  = (inflight_q[r] != 2'd0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < REG_NUM; r++) begin
        inflight_q[r] <= 2'd0;
        cnt_q[r]      <= '0;
      end
    end else if (flush_i) begin
      for (int r = 0; r < REG_NUM; r++) begin
        inflight_q[r] <= 2'd0;
        cnt_q[r]      <= '0;
      end
    end else begin
      for (int r = 0; r < REG_NUM; r++) begin
        // Newest accepted producer restarts the countdown
        if (acc_vec[r])
          cnt_q[r] <= issue_lat_i;
        else if (cnt_q[r] != '0)
          cnt_q[r] <= cnt_q[r] - CNT_W'(1);

        unique case ({acc_vec[r], wb_vec[r]})
          2'b10:   inflight_q[r] <= inflight_q[r] + 2'd1;
          2'b01:   inflight_q[r] <= inflight_q[r] - 2'd1;
          default: inflight_q[r] <= inflight_q[r];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: cycle vector table with expected stall/busy
// queued as each vector is driven, plus hand sequences for async reset.
module tb_reg_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic        issue_we_i;
  logic [4:0]  issue_waddr_i;
  logic [5:0]  issue_lat_i;
  logic        issue_re1_i;
  logic [4:0]  issue_raddr1_i;
  logic        issue_re2_i;
  logic [4:0]  issue_raddr2_i;
  logic        wb_valid_i;
  logic [4:0]  wb_waddr_i;
  logic        flush_i;
  logic        stall_o;
  logic [31:0] busy_o;

  reg_scoreboard #(.REG_NUM(32), .CNT_W(6)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .issue_valid_i  (issue_valid_i),
    .issue_we_i     (issue_we_i),
    .issue_waddr_i  (issue_waddr_i),
    .issue_lat_i    (issue_lat_i),
    .issue_re1_i    (issue_re1_i),
    .issue_raddr1_i (issue_raddr1_i),
    .issue_re2_i    (issue_re2_i),
    .issue_raddr2_i (issue_raddr2_i),
    .wb_valid_i     (wb_valid_i),
    .wb_waddr_i     (wb_waddr_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v;
    logic        we;
    logic [4:0]  wa;
    logic [5:0]  lat;
    logic        re1;
    logic [4:0]  r1;
    logic        re2;
    logic [4:0]  r2;
    logic        wbv;
    logic [4:0]  wba;
    logic        fl;
    logic        st;
    logic [31:0] bz;
  } row_t;

  typedef struct {
    logic        st;
    logic [31:0] bz;
    int          idx;
  } exp_t;

  row_t vec[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] b(input int n);
    return 32'h1 << n;
  endfunction

  function automatic void add(
    input logic v, input logic we, input logic [4:0] wa,
    input logic [5:0] lat, input logic re1, input logic [4:0] r1,
    input logic re2, input logic [4:0] r2, input logic wbv,
    input logic [4:0] wba, input logic fl, input logic st,
    input logic [31:0] bz);
    row_t t;
    t.v = v; t.we = we; t.wa = wa; t.lat = lat;
    t.re1 = re1; t.r1 = r1; t.re2 = re2; t.r2 = r2;
    t.wbv = wbv; t.wba = wba; t.fl = fl; t.st = st; t.bz = bz;
    vec.push_back(t);
  endfunction

  function automatic void iss(input logic [4:0] wa, input logic [5:0] lat,
                              input logic st, input logic [31:0] bz);
    add(1, 1, wa, lat, 0, 0, 0, 0, 0, 0, 0, st, bz);
  endfunction

  function automatic void rd1(input logic [4:0] r, input logic st,
                              input logic [31:0] bz);
    add(1, 0, 0, 0, 1, r, 0, 0, 0, 0, 0, st, bz);
  endfunction

  function automatic void rd2(input logic [4:0] r, input logic st,
                              input logic [31:0] bz);
    add(1, 0, 0, 0, 0, 0, 1, r, 0, 0, 0, st, bz);
  endfunction

  function automatic void wb(input logic [4:0] r, input logic [31:0] bz);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, r, 0, 0, bz);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle();
    issue_valid_i = 0; issue_we_i = 0; issue_waddr_i = 0;
    issue_lat_i = 0; issue_re1_i = 0; issue_raddr1_i = 0;
    issue_re2_i = 0; issue_raddr2_i = 0; wb_valid_i = 0;
    wb_waddr_i = 0; flush_i = 0;
  endtask

  initial begin
    exp_t  e;
    logic  act_st;

    // ALU chain: forwarding covers it, never stalls
    iss(5, 0, 0, b(5)); rd1(5, 0, b(5)); wb(5, 0);
    // Load-use: exactly one bubble
    iss(3, 1, 0, b(3)); rd1(3, 1, b(3)); rd1(3, 0, b(3)); wb(3, 0);
    // Divide: 33 bubbles on operand 2
    iss(8, 33, 0, b(8));
    for (int k = 0; k < 33; k++) rd2(8, 1, b(8));
    rd2(8, 0, b(8)); wb(8, 0);
    // WAW against a lat-10 producer, then underflow guard
    iss(4, 10, 0, b(4));
    for (int k = 0; k < 10; k++) iss(4, 0, 1, b(4));
    iss(4, 0, 0, b(4)); wb(4, b(4)); wb(4, 0); wb(4, 0);
    iss(4, 0, 0, b(4)); wb(4, 0);
    // Saturation at three in flight
    iss(6, 0, 0, b(6)); iss(6, 0, 0, b(6)); iss(6, 0, 0, b(6));
    iss(6, 0, 1, b(6)); iss(6, 0, 1, b(6));
    add(1, 1, 6, 0, 0, 0, 0, 0, 1, 6, 0, 1, b(6));
    iss(6, 0, 0, b(6)); wb(6, b(6)); wb(6, b(6)); wb(6, 0);
    // Accept and writeback to same register in one cycle
    iss(7, 0, 0, b(7));
    add(1, 1, 7, 0, 0, 0, 0, 0, 1, 7, 0, 0, b(7));
    wb(7, 0);
    // Flush with pending issue and writeback
    iss(10, 5, 0, b(10)); iss(11, 2, 0, b(10) | b(11));
    add(1, 1, 12, 3, 0, 0, 0, 0, 1, 10, 1, 0, 0);
    rd1(10, 0, 0); rd2(11, 0, 0); iss(12, 0, 0, b(12)); wb(12, 0);
    // r0 never tracked
    iss(0, 5, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 7, 1, 0, 1, 0, 1, 0, 0, 0, 0);

    idle();
    rst_i = 1'b1;
    #1;
    chk("reset_stall", 32'(stall_o), 32'd0);
    chk("reset_busy", busy_o, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < vec.size(); i++) begin
      @(negedge clk_i);
      issue_valid_i  = vec[i].v;
      issue_we_i     = vec[i].we;
      issue_waddr_i  = vec[i].wa;
      issue_lat_i    = vec[i].lat;
      issue_re1_i    = vec[i].re1;
      issue_raddr1_i = vec[i].r1;
      issue_re2_i    = vec[i].re2;
      issue_raddr2_i = vec[i].r2;
      wb_valid_i     = vec[i].wbv;
      wb_waddr_i     = vec[i].wba;
      flush_i        = vec[i].fl;
      e.st = vec[i].st; e.bz = vec[i].bz; e.idx = i;
      sb.push_back(e);
      #1 act_st = stall_o;
      @(posedge clk_i);
      #1;
      e = sb.pop_front();
      chk($sformatf("row%0d_stall", e.idx), 32'(act_st), 32'(e.st));
      chk($sformatf("row%0d_busy", e.idx), busy_o, e.bz);
    end

    // Async reset in the middle of a divide countdown
    @(negedge clk_i);
    idle();
    issue_valid_i = 1; issue_we_i = 1; issue_waddr_i = 8; issue_lat_i = 33;
    @(negedge clk_i);
    idle();
    issue_valid_i = 1; issue_re1_i = 1; issue_raddr1_i = 9;
    #1 chk("r9_unrelated", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    idle();
    issue_valid_i = 1; issue_re2_i = 1; issue_raddr2_i = 8;
    #1 chk("div_mid_stall", 32'(stall_o), 32'd1);
    chk("div_mid_busy", busy_o, b(8));
    #1 rst_i = 1'b1;
    #1 chk("async_rst_stall", 32'(stall_o), 32'd0);
    chk("async_rst_busy", busy_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1 chk("post_rst_read", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
